pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/pipelined_barrel_shifter.sv | 150 +++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate/shift unit with valid/ready on both sides; stage k applies a 2^k shift.
// Optional out_zero/out_carry flags are built only when BSH_FLAGS_EN is defined.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BSH_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_SHR = 2'b10;

  logic [SHW-1:0]   r_vld;
  logic [WIDTH-1:0] r_data [SHW];
  logic [SHW-1:0]   r_amt  [SHW];
  logic [1:0]       r_mode [SHW];

  logic [WIDTH-1:0] w_srcData  [SHW];
  logic [SHW-1:0]   w_srcAmt   [SHW];
  logic [1:0]       w_srcMode  [SHW];
  logic [WIDTH-1:0] w_nextData [SHW];
  logic [SHW-1:0]   w_srcVld;
  logic [SHW-1:0]   w_rdy;
  logic [SHW-1:0]   w_load;

  // Arithmetic fill uses the current MSB, which earlier SAR stages have kept equal to the original sign.
  function automatic logic [WIDTH-1:0] stepShift(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] mode, input int s);
    logic [WIDTH-1:0] fill;
    fill = {WIDTH{d[WIDTH-1]}};
    case (mode)
      MODE_ROR: return (d >> s) | (d << (WIDTH - s));
      MODE_ROL: return (d << s) | (d >> (WIDTH - s));
      MODE_SHR: return d >> s;
      default:  return (d >> s) | (fill << (WIDTH - s));
    endcase
  endfunction

  function automatic logic stepCarry(input logic [WIDTH-1:0] d,
                                     input logic [1:0] mode, input int s);
    logic [WIDTH-1:0] t;
    t = (mode == MODE_ROL) ? (d >> (WIDTH - s)) : (d >> (s - 1));
    return t[0];
  endfunction

  always_comb begin
    logic chain;
    w_srcData[0] = in_data;
    w_srcAmt[0]  = in_amt;
    w_srcMode[0] = in_mode;
    w_srcVld[0]  = in_valid;
    for (int k = 1; k < SHW; k++) begin
      w_srcData[k] = r_data[k-1];
      w_srcAmt[k]  = r_amt[k-1];
      w_srcMode[k] = r_mode[k-1];
      w_srcVld[k]  = r_vld[k-1];
    end
    // A stage can load when it is empty or everything downstream of it moves this cycle.
    chain = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      chain    = ~r_vld[k] | chain;
      w_rdy[k] = chain;
    end
    for (int k = 0; k < SHW; k++) begin
      w_nextData[k] = w_srcAmt[k][k] ? stepShift(w_srcData[k], w_srcMode[k], 1 << k)
                                     : w_srcData[k];
      w_load[k]     = w_rdy[k] & w_srcVld[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < SHW; k++) begin
        r_data[k] <= '0;
        r_amt[k]  <= '0;
        r_mode[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (w_rdy[k]) begin
          r_vld[k] <= w_srcVld[k];
        end
        if (w_load[k]) begin
          r_data[k] <= w_nextData[k];
          r_amt[k]  <= w_srcAmt[k];
          r_mode[k] <= w_srcMode[k];
        end
      end
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_vld[SHW-1];
  assign out_data  = r_data[SHW-1];

`ifdef BSH_FLAGS_EN
  logic [SHW-1:0] r_carry;
  logic           r_zero;
  logic [SHW-1:0] w_srcCarry;
  logic [SHW-1:0] w_nextCarry;

  // The carry only changes in stages that actually shift, so the last shifting stage decides it.
  always_comb begin
    w_srcCarry[0] = 1'b0;
    for (int k = 1; k < SHW; k++) begin
      w_srcCarry[k] = r_carry[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      w_nextCarry[k] = w_srcAmt[k][k] ? stepCarry(w_srcData[k], w_srcMode[k], 1 << k)
                                      : w_srcCarry[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= '0;
      r_zero  <= 1'b0;
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (w_load[k]) begin
          r_carry[k] <= w_nextCarry[k];
        end
      end
      if (w_load[SHW-1]) begin
        r_zero <= (w_nextData[SHW-1] == '0);
      end
    end
  end

  assign out_zero  = r_zero;
  assign out_carry = r_carry[SHW-1];
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomised self-checking bench for pipelined_barrel_shifter (WIDTH=8); reference model works on whole amounts.
module tb_pipelined_barrel_shifter;

  localparam int W   = 8;
  localparam int SHW = 3;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [SHW-1:0] in_amt;
  logic [1:0]     in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
`ifdef BSH_FLAGS_EN
  logic           out_zero;
  logic           out_carry;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  int callNo      = 0;

  logic [W-1:0] expQ [$];
  logic         expCq[$];
  int           tQ   [$];

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef BSH_FLAGS_EN
    ,
    .out_zero (out_zero),
    .out_carry(out_carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Whole-amount reference: rotates via a doubled word, arithmetic shift via a sign-extended word.
  function automatic logic [W-1:0] refShift(input logic [W-1:0] d, input int amt, input logic [1:0] mode);
    logic [2*W-1:0] wide;
    case (mode)
      2'b00: begin wide = {d, d} >> amt; return wide[W-1:0]; end
      2'b01: begin wide = {d, d} << amt; return wide[2*W-1:W]; end
      2'b10: return d >> amt;
      default: begin wide = {{W{d[W-1]}}, d} >> amt; return wide[W-1:0]; end
    endcase
  endfunction

  function automatic logic refCarry(input logic [W-1:0] d, input int amt, input logic [1:0] mode);
    logic [W-1:0] t;
    if (amt == 0) return 1'b0;
    t = (mode == 2'b01) ? (d >> (W - amt)) : (d >> (amt - 1));
    return t[0];
  endfunction

  function automatic void clearModel();
    expQ.delete();
    expCq.delete();
    tQ.delete();
  endfunction

  // One clock cycle: drive, sample mid-cycle, update the scoreboard, then cross the rising edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic [SHW-1:0] a,
                       input logic [1:0] m, input logic ordy,
                       output logic acc, output logic got, output logic ov, output logic ovx,
                       output logic [W-1:0] od, output logic oz, output logic oc,
                       output logic [W-1:0] ed, output logic ec, output logic qe);
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_mode   = m;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    got = out_valid && out_ready;
    ov  = out_valid;
    od  = out_data;
    oz  = 1'b0;
    oc  = 1'b0;
`ifdef BSH_FLAGS_EN
    oz = out_zero;
    oc = out_carry;
`endif
    ovx = (tQ.size() > 0) && (callNo - tQ[0] >= SHW);
    ed  = '0;
    ec  = 1'b0;
    qe  = 1'b0;
    if (got) begin
      if (expQ.size() == 0) qe = 1'b1;
      else begin
        ed = expQ.pop_front();
        ec = expCq.pop_front();
        void'(tQ.pop_front());
      end
    end
    if (acc) begin
      expQ.push_back(refShift(d, int'(a), m));
      expCq.push_back(refCarry(d, int'(a), m));
      tQ.push_back(callNo);
    end
    callNo++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b0;
    #12;
    nCompared++;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    nCompared++;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL post_reset_out_valid: got %b expected 0", out_valid); end
    nCompared++;
    if (out_data !== '0) begin nMismatched++; $display("[TB] FAIL post_reset_out_data: got %h expected 00", out_data); end
    nCompared++;
    if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
`ifdef BSH_FLAGS_EN
    nCompared++;
    if (out_zero !== 1'b0 || out_carry !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL post_reset_flags: got z=%b c=%b expected 0 0", out_zero, out_carry);
    end
`endif
  endtask

  task automatic test_latency();
    logic acc, got, ov, ovx, oz, oc, ec, qe;
    logic [W-1:0] od, ed;
    int lat;
    cycle(1'b1, 8'h81, 3'd1, 2'b00, 1'b1, acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
    nCompared++;
    if (acc !== 1'b1) begin nMismatched++; $display("[TB] FAIL latency_accept: got %b expected 1", acc); end
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      cycle(1'b0, '0, '0, 2'b00, 1'b1, acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
      if (got) begin
        lat = n;
        nCompared++;
        if (od !== 8'hC0) begin nMismatched++; $display("[TB] FAIL ror_81_1: got %h expected c0", od); end
      end
    end
    nCompared++;
    if (lat != SHW) begin nMismatched++; $display("[TB] FAIL latency_cycles: got %0d expected %0d", lat, SHW); end
  endtask

  task automatic test_modes();
    logic acc, got, ov, ovx, oz, oc, ec, qe;
    logic [W-1:0] od, ed;
    logic [1:0]     tMode[8];
    logic [W-1:0]   tData[8];
    logic [SHW-1:0] tAmt [8];
    logic [W-1:0]   tExp [8];
    int fed, outIdx, ix;
    tMode[0] = 2'b01; tData[0] = 8'h81; tAmt[0] = 3'd3; tExp[0] = 8'h0C;
    tMode[1] = 2'b10; tData[1] = 8'h80; tAmt[1] = 3'd7; tExp[1] = 8'h01;
    tMode[2] = 2'b11; tData[2] = 8'h80; tAmt[2] = 3'd7; tExp[2] = 8'hFF;
    tMode[3] = 2'b11; tData[3] = 8'h40; tAmt[3] = 3'd2; tExp[3] = 8'h10;
    for (int i = 4; i < 8; i++) begin
      tMode[i] = 2'(i - 4);
      tData[i] = W'($urandom) | 8'h81;
      tAmt[i]  = '0;
      tExp[i]  = tData[i];
    end
    fed = 0;
    outIdx = 0;
    for (int n = 0; n < 30 && outIdx < 8; n++) begin
      ix = (fed < 8) ? fed : 0;
      cycle(fed < 8, tData[ix], tAmt[ix], tMode[ix], 1'b1, acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
      if (acc) fed++;
      if (got) begin
        nCompared++;
        if (outIdx >= 8) begin nMismatched++; $display("[TB] FAIL modes_extra_output: got %h expected none", od); end
        else if (od !== tExp[outIdx]) begin
          nMismatched++; $display("[TB] FAIL modes_vec%0d: got %h expected %h", outIdx, od, tExp[outIdx]);
        end
        outIdx++;
      end
    end
    nCompared++;
    if (outIdx != 8) begin nMismatched++; $display("[TB] FAIL modes_count: got %0d expected 8", outIdx); end
  endtask

  task automatic test_back_to_back();
    logic acc, got, ov, ovx, oz, oc, ec, qe;
    logic [W-1:0] od, ed;
    logic expGot;
    for (int n = 0; n < 20 + SHW + 2; n++) begin
      cycle(n < 20, W'($urandom), SHW'($urandom_range(0, W - 1)), 2'($urandom), 1'b1,
            acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
      if (n < 20) begin
        nCompared++;
        if (acc !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_accept%0d: got %b expected 1", n, acc); end
      end
      expGot = (n >= SHW) && (n < 20 + SHW);
      nCompared++;
      if (got !== expGot) begin nMismatched++; $display("[TB] FAIL b2b_out_valid%0d: got %b expected %b", n, got, expGot); end
      if (got) begin
        nCompared++;
        if (qe || od !== ed) begin nMismatched++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", n, od, ed); end
      end
    end
  endtask

  task automatic test_stall();
    logic acc, got, ov, ovx, oz, oc, ec, qe;
    logic [W-1:0] od, ed;
    logic [W-1:0]   w  [5];
    logic [SHW-1:0] wa [5];
    logic [1:0]     wm [5];
    int idx, nOut, ix;
    for (int i = 0; i < 5; i++) begin
      w[i] = W'($urandom); wa[i] = SHW'($urandom_range(0, W - 1)); wm[i] = 2'($urandom);
    end
    idx = 0;
    for (int n = 0; n < 5; n++) begin
      cycle(1'b1, w[idx], wa[idx], wm[idx], 1'b0, acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
      if (acc) idx++;
    end
    nCompared++;
    if (idx != SHW) begin nMismatched++; $display("[TB] FAIL stall_accepted: got %0d expected %0d", idx, SHW); end
    nCompared++;
    if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_in_ready: got %b expected 0", in_ready); end
    nCompared++;
    if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_out_valid: got %b expected 1", out_valid); end
    nOut = 0;
    for (int n = 0; n < 20 && nOut < 5; n++) begin
      ix = (idx < 5) ? idx : 0;
      cycle(idx < 5, w[ix], wa[ix], wm[ix], 1'b1, acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
      if (n == 0) begin
        nCompared++;
        if ((acc && got) !== 1'b1) begin
          nMismatched++; $display("[TB] FAIL full_simultaneous: got acc=%b out=%b expected 1 1", acc, got);
        end
      end
      if (acc) idx++;
      if (got) begin
        nCompared++;
        if (qe || od !== ed) begin nMismatched++; $display("[TB] FAIL stall_data%0d: got %h expected %h", nOut, od, ed); end
        nOut++;
      end
    end
    nCompared++;
    if (nOut != 5 || idx != 5) begin nMismatched++; $display("[TB] FAIL stall_count: got out=%0d in=%0d expected 5 5", nOut, idx); end
  endtask

  task automatic test_random();
    logic acc, got, ov, ovx, oz, oc, ec, qe;
    logic [W-1:0] od, ed;
    for (int n = 0; n < 440; n++) begin
      cycle((n < 400) && ($urandom_range(0, 3) != 0), W'($urandom), SHW'($urandom_range(0, W - 1)),
            2'($urandom), (n >= 400) || ($urandom_range(0, 2) != 0),
            acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
      nCompared++;
      if (ov !== ovx) begin nMismatched++; $display("[TB] FAIL rand_out_valid%0d: got %b expected %b", n, ov, ovx); end
      if (got) begin
        nCompared++;
        if (qe || od !== ed) begin nMismatched++; $display("[TB] FAIL rand_data%0d: got %h expected %h", n, od, ed); end
`ifdef BSH_FLAGS_EN
        nCompared++;
        if (oc !== ec || oz !== (ed == '0)) begin
          nMismatched++; $display("[TB] FAIL rand_flags%0d: got z=%b c=%b expected z=%b c=%b", n, oz, oc, (ed == '0), ec);
        end
`endif
      end
    end
    nCompared++;
    if (expQ.size() != 0) begin nMismatched++; $display("[TB] FAIL rand_drain: got %0d pending expected 0", expQ.size()); end
  endtask

  task automatic test_midflight_reset();
    logic acc, got, ov, ovx, oz, oc, ec, qe;
    logic [W-1:0] od, ed;
    int stale, lat;
    for (int n = 0; n < 3; n++) begin
      cycle(1'b1, W'($urandom), SHW'($urandom_range(0, W - 1)), 2'($urandom), 1'b0,
            acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
    end
    nCompared++;
    if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL midreset_full: got %b expected 1", out_valid); end
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_immediate: got %b expected 0", out_valid); end
    clearModel();
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    stale = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(1'b0, '0, '0, 2'b00, 1'b1, acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
      if (got) stale++;
    end
    nCompared++;
    if (stale != 0) begin nMismatched++; $display("[TB] FAIL midreset_stale: got %0d results expected 0", stale); end
    cycle(1'b1, W'($urandom) | 8'h80, 3'd3, 2'b11, 1'b1, acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
    nCompared++;
    if (acc !== 1'b1) begin nMismatched++; $display("[TB] FAIL midreset_accept: got %b expected 1", acc); end
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      cycle(1'b0, '0, '0, 2'b00, 1'b1, acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
      if (got) begin
        lat = n;
        nCompared++;
        if (qe || od !== ed) begin nMismatched++; $display("[TB] FAIL midreset_data: got %h expected %h", od, ed); end
      end
    end
    nCompared++;
    if (lat != SHW) begin nMismatched++; $display("[TB] FAIL midreset_latency: got %0d expected %0d", lat, SHW); end
  endtask

`ifdef BSH_FLAGS_EN
  task automatic test_flags();
    logic acc, got, ov, ovx, oz, oc, ec, qe;
    logic [W-1:0] od, ed;
    int nOut;
    nOut = 0;
    for (int n = 0; n < 12 && nOut < 2; n++) begin
      if (n == 0)      cycle(1'b1, 8'h01, 3'd1, 2'b10, 1'b1, acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
      else if (n == 1) cycle(1'b1, 8'h80, 3'd1, 2'b01, 1'b1, acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
      else             cycle(1'b0, '0, '0, 2'b00, 1'b1, acc, got, ov, ovx, od, oz, oc, ed, ec, qe);
      if (got && nOut == 0) begin
        nCompared++;
        if (od !== 8'h00 || oz !== 1'b1 || oc !== 1'b1) begin
          nMismatched++; $display("[TB] FAIL flags_shr: got d=%h z=%b c=%b expected 00 1 1", od, oz, oc);
        end
      end
      if (got && nOut == 1) begin
        nCompared++;
        if (od !== 8'h01 || oz !== 1'b0 || oc !== 1'b1) begin
          nMismatched++; $display("[TB] FAIL flags_rol: got d=%h z=%b c=%b expected 01 0 1", od, oz, oc);
        end
      end
      if (got) nOut++;
    end
    nCompared++;
    if (nOut != 2) begin nMismatched++; $display("[TB] FAIL flags_count: got %0d expected 2", nOut); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_back_to_back();
    test_stall();
    test_random();
    test_midflight_reset();
`ifdef BSH_FLAGS_EN
    test_flags();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
